// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding NUM_REQ requesters into one FIFO write port
// Optional feature macro: FIFO_WR_ARBITER_WCNT_EN adds the 16-bit wr_count output.
// Ports:
//   clk_master       sole clock, rising edge
//   reset            synchronous active-high reset
//   req              per-requester "word available" flags
//   req_data         packed requester words, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack              combinational one-hot capture strobe for this edge
//   fifo_full        FIFO has no free entry
//   fifo_almost_full FIFO has exactly one free entry
//   wr_en_master     registered FIFO write strobe
//   data_in          registered FIFO write data
//   wr_count         (macro only) count of issued writes, wraps at 16 bits
//   grant            registered one-hot current owner, zero when idle
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          clk_master,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr_en_master,
    output logic [DATA_WIDTH-1:0]         data_in,
`ifdef FIFO_WR_ARBITER_WCNT_EN
    output logic [15:0]                   wr_count,
`endif
    output logic [NUM_REQ-1:0]            grant
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state_q;
    logic [IW-1:0]     owner_q, last_q, base, sel, ack_idx;
    logic [3:0]        cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic              wr_en_q, can_wr, found, hold, pick, release_d, ack_en;
    logic [DATA_WIDTH-1:0] data_q;
    assign grant        = grant_q;
    assign wr_en_master = wr_en_q;
    assign data_in      = data_q;
    always_comb begin
        // a write already in flight consumes the last free entry
        can_wr    = !fifo_full && !(wr_en_q && fifo_almost_full);
        // handover searches from owner+1, which equals the new last_owner+1
        base      = state_q == BURST ? owner_q : last_q;
        found     = 1'b0;
        sel       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[IW'((int'(base) + i) % NUM_REQ)]) begin
                found = 1'b1;
                sel   = IW'((int'(base) + i) % NUM_REQ);
            end
        end
        hold      = state_q == BURST && can_wr && req[owner_q] && cnt_q < 4'(BURST_MAX);
        release_d = state_q == BURST && can_wr && !hold;
        pick      = can_wr && found && !hold;
        ack_en    = !reset && (hold || pick);
        ack_idx   = hold ? owner_q : sel;
        ack       = ack_en ? NUM_REQ'(1) << ack_idx : '0;
    end
    always_ff @(posedge clk_master) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_en_q <= ack_en;
            if (ack_en) data_q <= req_data[int'(ack_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (release_d) last_q <= owner_q;
            if (hold) begin
                cnt_q <= cnt_q + 4'd1;
            end else if (pick) begin
                state_q <= BURST;
                owner_q <= sel;
                grant_q <= NUM_REQ'(1) << sel;
                cnt_q   <= 4'd1;
            end else if (release_d) begin
                state_q <= IDLE;
                grant_q <= '0;
                cnt_q   <= '0;
            end
        end
    end
`ifdef FIFO_WR_ARBITER_WCNT_EN
    logic [15:0] wcnt_q;
    assign wr_count = wcnt_q;
    always_ff @(posedge clk_master) begin
        if (reset) wcnt_q <= '0;
        else if (ack_en) wcnt_q <= wcnt_q + 16'd1;
    end
`endif
endmodule
